// File: rtl/count_times_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : count_times_checker_if
// Purpose  : Beat handshake (valid/ready/data) plus terminal-value bus for
//            the count-times checker.
// Revision : 1.0
// ============================================================================
interface count_times_checker_if #(
  parameter int N = 32
);
  localparam int W = $clog2(N + 1);

  logic         i_valid;
  logic [W-1:0] i_data;
  logic [W-1:0] i_max;
  logic         o_ready;

  modport master (
    output i_valid,
    output i_data,
    output i_max,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_data,
    input  i_max,
    output o_ready
  );
endinterface
`default_nettype wire

// File: rtl/count_times_checker.sv
`default_nettype none
// ============================================================================
// Module   : count_times_checker
// Purpose  : Receive-side checker for the "value k repeated k times" stream.
//            Optional macro COUNT_TIMES_CHK_RESYNC_EN: resync out of ERR on a 0.
// Revision : 1.0
// ============================================================================
module count_times_checker #(
  parameter  int N = 32,
  localparam int W = $clog2(N + 1)
) (
  input  wire                  clk,
  input  wire                  rstn,
  input  wire                  i_clr,
  count_times_checker_if.slave bus,
  output logic [W-1:0]         o_exp,
  output logic                 o_run_done,
  output logic [W-1:0]         o_run_val,
  output logic                 o_seq_done,
  output logic                 o_err,
  output logic [1:0]           o_err_code
);

  localparam logic [W-1:0] c_n_max = W'(N);
  localparam logic [W-1:0] c_one   = W'(1);
`ifdef COUNT_TIMES_CHK_RESYNC_EN
  localparam bit c_resync = 1'b1;
`else
  localparam bit c_resync = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t       r_state,    w_state_nxt;
  logic [W-1:0] r_exp_val,  w_exp_val_nxt;
  logic [W-1:0] r_rep_cnt,  w_rep_cnt_nxt;
  logic [W-1:0] r_max_q,    w_max_q_nxt;
  logic         r_run_done, w_run_done_nxt;
  logic [W-1:0] r_run_val,  w_run_val_nxt;
  logic         r_seq_done, w_seq_done_nxt;
  logic         r_err,      w_err_nxt;
  logic [1:0]   r_err_code, w_err_code_nxt;

  logic         w_accept;
  logic         w_do_start;
  logic [W-1:0] w_run_len;
  logic [W-1:0] w_rep_inc;

  assign bus.o_ready = (r_state != S_DONE);
  assign w_accept    = bus.i_valid && bus.o_ready;
  // A resync beat in ERR is handled exactly like the first beat from IDLE.
  assign w_do_start  = w_accept && ((r_state == S_IDLE) ||
                       (c_resync && (r_state == S_ERR) && (bus.i_data == '0)));
  assign w_run_len   = (r_exp_val == '0) ? c_one : r_exp_val;
  assign w_rep_inc   = r_rep_cnt + c_one;

  always_comb begin
    w_state_nxt    = r_state;
    w_exp_val_nxt  = r_exp_val;
    w_rep_cnt_nxt  = r_rep_cnt;
    w_max_q_nxt    = r_max_q;
    w_run_done_nxt = 1'b0;
    w_run_val_nxt  = r_run_val;
    w_seq_done_nxt = 1'b0;
    w_err_nxt      = r_err;
    w_err_code_nxt = r_err_code;

    case (r_state)
      S_IDLE, S_ERR: begin
        if (w_do_start) begin
          w_max_q_nxt    = bus.i_max;
          w_err_nxt      = 1'b0;
          w_err_code_nxt = 2'b00;
          if (bus.i_max > c_n_max) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = 2'b11;
            w_state_nxt    = S_ERR;
          end else if (bus.i_data != '0) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = 2'b01;
            w_state_nxt    = S_ERR;
          end else if (bus.i_max == '0) begin
            w_run_done_nxt = 1'b1;
            w_run_val_nxt  = '0;
            w_seq_done_nxt = 1'b1;
            w_state_nxt    = S_DONE;
          end else begin
            w_run_done_nxt = 1'b1;
            w_run_val_nxt  = '0;
            w_exp_val_nxt  = c_one;
            w_rep_cnt_nxt  = '0;
            w_state_nxt    = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_accept) begin
          if (bus.i_data > r_max_q) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = 2'b10;
            w_state_nxt    = S_ERR;
          end else if (bus.i_data != r_exp_val) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = 2'b01;
            w_state_nxt    = S_ERR;
          end else if (w_rep_inc == w_run_len) begin
            w_run_done_nxt = 1'b1;
            w_run_val_nxt  = r_exp_val;
            w_rep_cnt_nxt  = '0;
            if (r_exp_val == r_max_q) begin
              w_seq_done_nxt = 1'b1;
              w_state_nxt    = S_DONE;
            end else begin
              w_exp_val_nxt  = r_exp_val + c_one;
            end
          end else begin
            w_rep_cnt_nxt  = w_rep_inc;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Clear overrides everything, including a beat accepted this cycle.
    if (i_clr) begin
      w_state_nxt    = S_IDLE;
      w_exp_val_nxt  = '0;
      w_rep_cnt_nxt  = '0;
      w_max_q_nxt    = '0;
      w_run_done_nxt = 1'b0;
      w_run_val_nxt  = '0;
      w_seq_done_nxt = 1'b0;
      w_err_nxt      = 1'b0;
      w_err_code_nxt = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_exp_val  <= '0;
      r_rep_cnt  <= '0;
      r_max_q    <= '0;
      r_run_done <= 1'b0;
      r_run_val  <= '0;
      r_seq_done <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_exp_val  <= w_exp_val_nxt;
      r_rep_cnt  <= w_rep_cnt_nxt;
      r_max_q    <= w_max_q_nxt;
      r_run_done <= w_run_done_nxt;
      r_run_val  <= w_run_val_nxt;
      r_seq_done <= w_seq_done_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
    end
  end

  assign o_exp      = (r_state == S_RUN) ? r_exp_val : '0;
  assign o_run_done = r_run_done;
  assign o_run_val  = r_run_val;
  assign o_seq_done = r_seq_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_count_times_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_times_checker
// Purpose  : Directed plus randomized bench with a sequence-list reference
//            model for count_times_checker.
// Revision : 1.0
// ============================================================================
module tb_count_times_checker;
  localparam int N = 32;
  localparam int W = $clog2(N + 1);
`ifdef COUNT_TIMES_CHK_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic         clk  = 1'b0;
  logic         rstn = 1'b0;
  logic         clr  = 1'b0;
  logic [W-1:0] o_exp;
  logic         o_run_done;
  logic [W-1:0] o_run_val;
  logic         o_seq_done;
  logic         o_err;
  logic [1:0]   o_err_code;

  count_times_checker_if #(.N(N)) bus ();

  count_times_checker #(.N(N)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_clr      (clr),
    .bus        (bus.slave),
    .o_exp      (o_exp),
    .o_run_done (o_run_done),
    .o_run_val  (o_run_val),
    .o_seq_done (o_seq_done),
    .o_err      (o_err),
    .o_err_code (o_err_code)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the full expected sequence is expanded into a list and
  // walked with an index.
  int m_seq[$];
  int m_pos, m_max, m_code, e_run_val;
  bit m_active, m_bubble, m_err, e_run_done, e_seq_done, m_acc;

  function automatic void m_clear();
    m_seq.delete();
    m_pos = 0; m_max = 0; m_code = 0; e_run_val = 0;
    m_active = 0; m_bubble = 0; m_err = 0;
    e_run_done = 0; e_seq_done = 0;
  endfunction

  function automatic void m_fail(int code);
    m_err = 1; m_code = code; m_active = 0;
  endfunction

  function automatic void m_start(int mx, int d);
    if (mx > N) begin m_fail(3); return; end
    if (d != 0) begin m_fail(1); return; end
    m_max = mx;
    m_seq.delete();
    for (int v = 0; v <= mx; v++)
      for (int r = 0; r < ((v < 1) ? 1 : v); r++) m_seq.push_back(v);
    e_run_done = 1; e_run_val = 0; m_pos = 1;
    if (m_pos == m_seq.size()) begin
      e_seq_done = 1; m_bubble = 1; m_active = 0;
    end else m_active = 1;
  endfunction

  function automatic void m_run(int d);
    if (d > m_max) begin m_fail(2); return; end
    if (d != m_seq[m_pos]) begin m_fail(1); return; end
    m_pos++;
    if (m_pos == m_seq.size()) begin
      e_run_done = 1; e_run_val = d;
      e_seq_done = 1; m_bubble = 1; m_active = 0;
    end else if (m_seq[m_pos] != d) begin
      e_run_done = 1; e_run_val = d;
    end
  endfunction

  function automatic void m_step(bit c, bit v, int d, int mx);
    e_run_done = 0; e_seq_done = 0; m_acc = 0;
    if (c) begin m_clear(); return; end
    if (m_bubble) begin m_bubble = 0; return; end
    if (!v) return;
    m_acc = 1;
    if (m_err) begin
      if (RESYNC && d == 0) begin
        m_err = 0; m_code = 0;
        m_start(mx, d);
      end
    end else if (!m_active) m_start(mx, d);
    else m_run(d);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input int expv);
    tests++;
    assert (obs === 32'(expv)) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    check("ready",    32'(bus.o_ready),  m_bubble ? 0 : 1);
    check("exp",      32'(o_exp),        m_active ? m_seq[m_pos] : 0);
    check("run_done", 32'(o_run_done),   int'(e_run_done));
    check("seq_done", 32'(o_seq_done),   int'(e_seq_done));
    check("err",      32'(o_err),        int'(m_err));
    check("err_code", 32'(o_err_code),   m_code);
    if (e_run_done) check("run_val", 32'(o_run_val), e_run_val);
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step(clr, bus.i_valid, int'(bus.i_data), int'(bus.i_max));
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input int d, input int mx);
    bus.i_valid = 1'b1; bus.i_data = W'(d); bus.i_max = W'(mx);
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (m_acc) return;
    end
    check("accept_timeout", 32'(0), 1);
  endtask

  task automatic idle(input int n);
    bus.i_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic clr_pulse();
    bus.i_valid = 1'b0; clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic rst_pulse();
    bus.i_valid = 1'b0; rstn = 1'b0;
    #1;
    m_clear();
    check_all();
    @(negedge clk);
    rstn = 1'b1;
    idle(1);
  endtask

  initial begin
    int q[$];
    int mx, d;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_max = '0;
    m_clear();
    @(negedge clk);
    check_all();
    rstn = 1'b1;
    idle(2);

    // Full sequence up to 4, then the DONE bubble
    foreach (q[i]) q.delete(i);
    q = '{0, 1, 2, 2, 3, 3, 3, 4, 4, 4, 4};
    foreach (q[i]) send(q[i], 4);
    idle(3);

    // Degenerate max 0 with valid held: accept every second cycle
    send(0, 0); send(0, 0); send(0, 0);
    idle(2);

    // Missing repeat of 2 -> mismatch, then beats dropped
    q = '{0, 1, 2, 3, 3, 1};
    foreach (q[i]) send(q[i], 3);
    idle(1);
    clr_pulse();

    // Over-max data, then illegal terminal value
    q = '{0, 1, 5};
    foreach (q[i]) send(q[i], 3);
    clr_pulse();
    send(0, 33);
    idle(1);
    clr_pulse();

    // Reset mid-run discards progress
    q = '{0, 1, 2};
    foreach (q[i]) send(q[i], 3);
    rst_pulse();
    q = '{0, 1, 2, 2, 3, 3, 3};
    foreach (q[i]) send(q[i], 3);
    idle(2);

    // Clear simultaneous with a valid beat
    send(0, 3); send(1, 3);
    bus.i_valid = 1'b1; bus.i_data = '0; clr = 1'b1;
    cycle();
    clr = 1'b0;
    idle(2);

    // Error followed by 7,0,1 (resync only when enabled)
    send(5, 3);
    q = '{7, 0, 1};
    foreach (q[i]) send(q[i], 1);
    idle(2);
    clr_pulse();

    // Randomized sequences with occasional corruption and idle gaps
    for (int it = 0; it < 30; it++) begin
      mx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(33, 40))
                                       : int'($urandom_range(0, 7));
      q.delete();
      for (int v = 0; v <= mx && v <= 7; v++)
        for (int r = 0; r < ((v < 1) ? 1 : v); r++) q.push_back(v);
      foreach (q[i]) begin
        d = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 15)) : q[i];
        send(d, (i == 0) ? mx : int'($urandom_range(0, 63)));
        if ($urandom_range(0, 5) == 0) idle(1);
      end
      idle(2);
      if (m_err) begin
        send($urandom_range(0, 2), $urandom_range(0, 4));
        clr_pulse();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
